// File: rtl/card_shuffle_ctrl_if.sv
// Card store port bundle: two combinational read ports and one write port.
// The shuffle controller drives it through the master modport; the store sits on the slave side.
interface card_shuffle_ctrl_if #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned SYM_W = 3
);
  logic [IDX_W-1:0] mem_raddr_a;
  logic [IDX_W-1:0] mem_raddr_b;
  logic [SYM_W-1:0] mem_rdata_a;
  logic [SYM_W-1:0] mem_rdata_b;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [SYM_W-1:0] mem_wdata;

  modport master (
    output mem_raddr_a, mem_raddr_b, mem_we, mem_waddr, mem_wdata,
    input  mem_rdata_a, mem_rdata_b
  );

  modport slave (
    input  mem_raddr_a, mem_raddr_b, mem_we, mem_waddr, mem_wdata,
    output mem_rdata_a, mem_rdata_b
  );
endinterface

// File: rtl/card_shuffle_ctrl.sv
// In-place Fisher-Yates shuffle of the card store, driven by a 16-bit Galois LFSR.
// Define CARD_SHUFFLE_FILL_EN to rewrite the canonical pair layout before every shuffle.
module card_shuffle_ctrl #(
  parameter int unsigned N_CARDS   = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned SYM_W     = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                seed_we,
  input  logic [15:0]         seed,
  output logic                busy,
  output logic                done,
  card_shuffle_ctrl_if.master mem
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [15:0] LfsrMask = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
`ifdef CARD_SHUFFLE_FILL_EN
    StFill,
`endif
    StPick,
    StSwapA,
    StSwapB,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    i_q, i_d;
  logic [IDX_W-1:0]    j_q, j_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [SYM_W-1:0]    tmp_q, tmp_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDX_W-1:0]    draw;

  // Smallest all-ones mask covering v, i.e. 2^ceil(log2(v+1))-1.
  function automatic logic [IDX_W-1:0] range_mask(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] m;
    m = v;
    for (int k = 1; k < int'(IDX_W); k++) m = m | (v >> k);
    return m;
  endfunction

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    retry_d = retry_q;
    tmp_d   = tmp_q;
    lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrMask) : (lfsr_q >> 1);
    draw    = lfsr_q[IDX_W-1:0] & range_mask(i_q);

    case (state_q)
      StIdle: begin
        if (seed_we) lfsr_d = (seed == '0) ? LFSR_SEED : seed;
        if (start) begin
`ifdef CARD_SHUFFLE_FILL_EN
          state_d = StFill;
          j_d     = '0;
`else
          state_d = StPick;
`endif
        end
      end
`ifdef CARD_SHUFFLE_FILL_EN
      // j doubles as the fill write pointer.
      StFill: begin
        j_d = j_q + 1'b1;
        if (j_q == IDX_W'(N_CARDS - 1)) begin
          i_d     = IDX_W'(N_CARDS - 1);
          j_d     = '0;
          state_d = StPick;
        end
      end
`endif
      StPick: begin
        if (draw <= i_q) begin
          j_d     = draw;
          retry_d = '0;
          state_d = StSwapA;
        end else if (retry_q == RetryW'(MAX_RETRY)) begin
          // Halving a masked draw always lands inside 0..i.
          j_d     = draw >> 1;
          retry_d = '0;
          state_d = StSwapA;
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end
      StSwapA: begin
        tmp_d   = mem.mem_rdata_a;
        state_d = StSwapB;
      end
      StSwapB: begin
        if (i_q == IDX_W'(1)) begin
          state_d = StDone;
        end else begin
          i_d     = i_q - 1'b1;
          state_d = StPick;
        end
      end
      StDone: begin
        i_d     = IDX_W'(N_CARDS - 1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StPick) || (state_d == StSwapA) || (state_d == StSwapB);
`ifdef CARD_SHUFFLE_FILL_EN
    if (state_d == StFill) busy_d = 1'b1;
`endif
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= IDX_W'(N_CARDS - 1);
      j_q     <= '0;
      retry_q <= '0;
      tmp_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      retry_q <= retry_d;
      tmp_q   <= tmp_d;
      lfsr_q  <= lfsr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    mem.mem_raddr_a = busy_q ? i_q : '0;
    mem.mem_raddr_b = busy_q ? j_q : '0;
    mem.mem_we      = 1'b0;
    mem.mem_waddr   = '0;
    mem.mem_wdata   = '0;
    case (state_q)
`ifdef CARD_SHUFFLE_FILL_EN
      StFill: begin
        mem.mem_we    = 1'b1;
        mem.mem_waddr = j_q;
        mem.mem_wdata = SYM_W'(j_q >> 1);
      end
`endif
      StSwapA: begin
        mem.mem_we    = 1'b1;
        mem.mem_waddr = i_q;
        mem.mem_wdata = mem.mem_rdata_b;
      end
      StSwapB: begin
        mem.mem_we    = 1'b1;
        mem.mem_waddr = j_q;
        mem.mem_wdata = tmp_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/card_shuffle_ctrl.md
Name: card_shuffle_ctrl

Overview:
- Sequencer that randomises the card store before each round of the memory game.
- Runs an in-place Fisher–Yates shuffle over the N_CARDS-entry card register array, driven by a free-running 16-bit LFSR.
- Owns the card store's write port and two read addresses while busy; the game-logic and VGA readers use the store only when busy=0.
- Sits between the centre-button start event and the card array feeding the VGA grid renderer.

Parameters:
- N_CARDS, 16, number of cards; power of two, even.
- IDX_W, 4, log2(N_CARDS).
- SYM_W, 3, card symbol width; N_CARDS/2 symbols.
- LFSR_SEED, 16'hACE1, LFSR value on reset and on a zero seed load.
- MAX_RETRY, 3, rejected draws allowed before fallback index.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- start  in  1  level; sampled in IDLE only
- seed_we  in  1  load seed into LFSR; honoured in IDLE only
- seed  in  16  LFSR seed value
- busy  out  1  shuffle in progress; store owned by this block
- done  out  1  single-cycle completion pulse
- mem_raddr_a  out  IDX_W  store read address A (= i)
- mem_raddr_b  out  IDX_W  store read address B (= j)
- mem_rdata_a  in  SYM_W  combinational read data for address A
- mem_rdata_b  in  SYM_W  combinational read data for address B
- mem_we  out  1  store write enable
- mem_waddr  out  IDX_W  store write address
- mem_wdata  out  SYM_W  store write data

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr_a=0, mem_raddr_b=0, i=N_CARDS-1, j=0, retry=0, LFSR=LFSR_SEED.
- LFSR:
  - Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Shifts every non-reset cycle.
  - In IDLE, seed_we=1 loads seed, or LFSR_SEED if seed==0; that cycle it does not shift.
- Store interface:
  - All outputs are Moore-decoded from registered state, i, j and tmp.
  - The store read is combinational, so data is valid in the same cycle as the address.
- IDLE: busy=0. start=1 moves to FILL (FILL_EN) or PICK; busy=1 from the next cycle.
- FILL (FILL_EN only):
  - Cycle k writes mem[k]=k>>1, for k=0..N_CARDS-1.
  - Then i=N_CARDS-1 and the state goes to PICK.
- PICK, once per cycle:
  - mask = 2^ceil(log2(i+1))-1; r = LFSR[IDX_W-1:0] & mask.
  - If r<=i: j=r, retry=0, go to SWAP_A.
  - Else retry++. If retry==MAX_RETRY: j=r>>1 (always <=i), retry=0, go to SWAP_A.
- SWAP_A:
  - mem_we=1, mem_waddr=i, mem_wdata=mem_rdata_b.
  - tmp <= mem_rdata_a.
- SWAP_B:
  - mem_we=1, mem_waddr=j, mem_wdata=tmp.
  - If i==1 go to DONE, else i--, go to PICK.
- j==i: both writes still issue; the store is unchanged.
- DONE: done=1, busy=0, i=N_CARDS-1, go to IDLE.
- Timing:
  - Swap loop: 15 iterations, each (PICK cycles + 2).
  - Total busy cycles: 45..90 at MAX_RETRY=3; add 16 with FILL_EN.
- start=1 outside IDLE is ignored.
- start held high continuously: one IDLE cycle after DONE, then a new shuffle begins.
- seed_we outside IDLE is ignored.
- Reset mid-operation: next cycle IDLE, busy=0, mem_we=0, no further writes. Store contents are unspecified (a symbol may be duplicated if reset hits SWAP_B), and the caller must re-run start.
- Result invariant after a completed run: the store is a permutation of its contents at start. With FILL_EN, each symbol 0..N_CARDS/2-1 appears exactly twice.

Optional Feature:
- Macro: CARD_SHUFFLE_FILL_EN.
- Defined: every start first executes FILL, rewriting the canonical pair layout, so each round begins from a clean deck and recovers from a mid-shuffle reset.
- Undefined: FILL state absent; start goes straight to PICK and shuffles the existing store contents in place.

Test Plan:
- Reset for 3 cycles -> busy=0, done=0, mem_we=0, mem_waddr=0, mem_raddr_a=0, mem_raddr_b=0.
- FILL_EN, seed_we with seed=16'h0001, start pulse next cycle -> busy high 61..106 cycles, done pulses exactly once with busy=0, store holds each symbol 0..7 exactly twice.
- Same seed_we/start sequence run twice -> identical final store. Repeating with seed=16'hACE1 -> differs from the 16'h0001 result.
- seed_we with seed=0, then start -> final store identical to the run seeded with 16'hACE1.
- start pulsed during busy -> ignored, exactly one done. start held high -> done, 1 IDLE cycle, then busy=1 again.
- FILL_EN, reset asserted in a SWAP_B cycle -> next cycle busy=0, mem_we=0. A new start yields a valid pair multiset and a done pulse.
